// File: rtl/da_serial_bank_if.sv
// Handshake bundle for da_serial_bank: parallel word in, K-bit bit-planes out.
// Revision: 1.0
`default_nettype none

interface da_serial_bank_if #(
  parameter int N = 16,
  parameter int K = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [K*N-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [K-1:0]   out_bits;
  logic           out_sign;
  logic           out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bits, out_sign, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bits, out_sign, out_last
  );
endinterface

`default_nettype wire

// File: rtl/da_serial_bank.sv
// ---------------------------------------------------------------------------
// da_serial_bank : K-tap bit-serialiser feeding a DA LUT address, one bit-plane
//                  per beat. Optional macro DA_SER_MSB_FIRST_EN selects MSB-first.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module da_serial_bank #(
  parameter int N = 16,
  parameter int K = 8
) (
  input  wire logic      clk,
  input  wire logic      rst,
  da_serial_bank_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] c_CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] c_CNT_PRE  = CW'(N - 2);
  localparam logic [0:0]    c_IDLE     = 1'b0;
  localparam logic [0:0]    c_SHIFT    = 1'b1;
`ifdef DA_SER_MSB_FIRST_EN
  localparam logic          c_SIGN_FIRST = 1'b1;
`else
  localparam logic          c_SIGN_FIRST = 1'b0;
`endif

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_sh [K];
  logic          r_sign;
  logic          r_last;

  logic [N-1:0]  w_shift [K];
  logic [K-1:0]  w_bits;
  logic          w_valid;
  logic          w_beat;
  logic          w_at_last;
  logic          w_ready;
  logic          w_load;
  logic          w_sign_next;

  generate
    for (genvar k = 0; k < K; k++) begin : g_tap
`ifdef DA_SER_MSB_FIRST_EN
      assign w_bits[k]  = r_sh[k][N-1];
      assign w_shift[k] = {r_sh[k][N-2:0], 1'b0};
`else
      assign w_bits[k]  = r_sh[k][0];
      assign w_shift[k] = {r_sh[k][N-1], r_sh[k][N-1:1]};
`endif
    end
  endgenerate

  assign w_valid   = (r_state == c_SHIFT);
  assign w_beat    = w_valid && bus.out_ready;
  assign w_at_last = (r_cnt == c_CNT_LAST);
  // out_ready -> in_ready is combinational so the next word lands with no bubble
  assign w_ready   = !w_valid || (w_at_last && bus.out_ready);
  assign w_load    = bus.in_valid && w_ready;

`ifdef DA_SER_MSB_FIRST_EN
  assign w_sign_next = 1'b0;
`else
  assign w_sign_next = (r_cnt == c_CNT_PRE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_last  <= 1'b0;
      for (int k = 0; k < K; k++) r_sh[k] <= '0;
    end else if (w_load) begin
      r_state <= c_SHIFT;
      r_cnt   <= '0;
      r_sign  <= c_SIGN_FIRST;
      r_last  <= 1'b0;
      for (int k = 0; k < K; k++) r_sh[k] <= bus.in_data[k*N +: N];
    end else if (w_beat) begin
      if (w_at_last) begin
        // registers keep the final plane so out_bits holds while idle
        r_state <= c_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_sign <= w_sign_next;
        r_last <= (r_cnt == c_CNT_PRE);
        for (int k = 0; k < K; k++) r_sh[k] <= w_shift[k];
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = w_valid;
  assign bus.out_bits  = w_bits;
  assign bus.out_sign  = r_sign;
  assign bus.out_last  = r_last;

endmodule

`default_nettype wire

// File: tb/tb_da_serial_bank.sv
// Bench for da_serial_bank: directed vector table, corner sequences and a
// randomized run against a queue-based beat model.
`default_nettype none

module tb_da_serial_bank;

  localparam int N = 4;
  localparam int K = 2;

  typedef struct packed {
    logic [K-1:0] bits;
    logic         sign;
    logic         last;
  } beat_t;

  typedef struct {
    logic [K*N-1:0] data;
    logic [K-1:0]   exp [N];
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  da_serial_bank_if #(.N(N), .K(K)) bus ();

  da_serial_bank #(.N(N), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef DA_SER_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  beat_t q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    n_acc = 0;
  vec_t  tbl [3];

  function automatic beat_t model_beat(input logic [K*N-1:0] d, input int b);
    beat_t r;
    int    idx;
    idx = MSB_FIRST ? (N - 1 - b) : b;
    for (int k = 0; k < K; k++) r.bits[k] = d[k*N + idx];
    r.sign = MSB_FIRST ? (b == 0) : (b == N - 1);
    r.last = (b == N - 1);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [K*N-1:0] d, input logic ordy);
    logic exp_valid;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    exp_valid = (q.size() != 0);
    if (!rst) begin
      check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      check("in_ready", 32'(bus.in_ready), 32'(!exp_valid || (q.size() == 1 && ordy)));
      if (exp_valid) begin
        check("out_bits", 32'(bus.out_bits), 32'(q[0].bits));
        check("out_sign", 32'(bus.out_sign), 32'(q[0].sign));
        check("out_last", 32'(bus.out_last), 32'(q[0].last));
      end
    end
  endtask

  task automatic step();
    logic hs_in, hs_out;
    logic [K*N-1:0] d;
    hs_in  = bus.in_valid && (q.size() == 0 || (q.size() == 1 && bus.out_ready));
    hs_out = (q.size() != 0) && bus.out_ready;
    d      = bus.in_data;
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (hs_out) begin
        void'(q.pop_front());
        n_acc++;
      end
      if (hs_in) for (int b = 0; b < N; b++) q.push_back(model_beat(d, b));
    end
    #1;
  endtask

  task automatic cycle(input logic iv, input logic [K*N-1:0] d, input logic ordy);
    drive(iv, d, ordy);
    step();
  endtask

  initial begin
    logic         pat [7];
    logic [K-1:0] prev_bits;
    logic [7:0]   last_mask;
    logic [7:0]   rdy_mask;
    logic [31:0]  rnd;
    int           acc0;

    tbl[0].data = 8'hE5;
    tbl[1].data = 8'hF0;
    tbl[2].data = 8'h18;
`ifdef DA_SER_MSB_FIRST_EN
    tbl[0].exp = '{2'b10, 2'b11, 2'b10, 2'b01};
    tbl[1].exp = '{2'b10, 2'b10, 2'b10, 2'b10};
    tbl[2].exp = '{2'b01, 2'b00, 2'b00, 2'b10};
`else
    tbl[0].exp = '{2'b01, 2'b10, 2'b11, 2'b10};
    tbl[1].exp = '{2'b10, 2'b10, 2'b10, 2'b10};
    tbl[2].exp = '{2'b10, 2'b00, 2'b00, 2'b01};
`endif

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;

    // reset state
    rst = 1'b1;
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_bits", 32'(bus.out_bits), 32'd0);
    check("rst_out_sign", 32'(bus.out_sign), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    step();

    // directed vectors
    for (int v = 0; v < 3; v++) begin
      cycle(1'b1, tbl[v].data, 1'b1);
      for (int b = 0; b < N; b++) begin
        drive(1'b0, '0, 1'b1);
        check("tbl_bits", 32'(bus.out_bits), 32'(tbl[v].exp[b]));
        check("tbl_last", 32'(bus.out_last), 32'(b == N - 1));
        step();
      end
      cycle(1'b0, '0, 1'b1);
    end

    // backpressure
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    cycle(1'b1, 8'hE5, 1'b1);
    acc0 = n_acc;
    prev_bits = '0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, '0, pat[i]);
      if (i > 0 && !pat[i-1]) check("bp_hold", 32'(bus.out_bits), 32'(prev_bits));
      prev_bits = bus.out_bits;
      step();
    end
    check("bp_beats", 32'(n_acc - acc0), 32'd4);
    cycle(1'b0, '0, 1'b1);

    // back-to-back words
    cycle(1'b1, 8'hE5, 1'b1);
    acc0 = n_acc;
    last_mask = '0;
    rdy_mask  = '0;
    for (int i = 0; i < 8; i++) begin
      drive(i < 4, 8'h18, 1'b1);
      last_mask[i] = bus.out_valid && bus.out_last;
      rdy_mask[i]  = bus.in_ready;
      step();
    end
    check("b2b_beats", 32'(n_acc - acc0), 32'd8);
    check("b2b_last", 32'(last_mask), 32'h88);
    check("b2b_ready", 32'(rdy_mask), 32'h88);
    cycle(1'b0, '0, 1'b1);

    // reset mid-word
    cycle(1'b1, 8'hE5, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    rst = 1'b1;
    cycle(1'b0, '0, 1'b1);
    rst = 1'b0;
    acc0 = n_acc;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1);
      check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
      step();
    end
    check("mid_rst_beats", 32'(n_acc - acc0), 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rnd = $urandom;
      rst = ($urandom % 150) == 0;
      cycle(($urandom % 3) != 0, rnd[K*N-1:0], ($urandom % 4) != 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 2 * N; i++) cycle(1'b0, '0, 1'b1);
    check("drain_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
